dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                access size encoding, responder FSM states, byte-enable
//                patterns and a byte-enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [3:0] C_BE_BYTE = 4'b0001;
    localparam logic [3:0] C_BE_HALF = 4'b0011;
    localparam logic [3:0] C_BE_WORD = 4'b1111;

    // Byte-enable pattern for an access of the given size at a lane offset.
    // The offset is expected to be already aligned to the access size.
    function automatic logic [3:0] byte_enable(input size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = C_BE_BYTE << off;
            SZ_HALF: be = C_BE_HALF << off;
            default: be = C_BE_WORD;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : Word-organised RAM, DEPTH x WIDTH, synchronous byte-enabled
//                write and synchronous read. The array is never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [WIDTH/8-1:0]   be,
    input  logic [AW-1:0]        addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Byte-lane write and registered read (read returns pre-write contents).
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WIDTH/8; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side responder for the core load/store port. Accepts
//                one request at a time, inserts WAIT_CYCLES wait states, then
//                performs a byte/half/word access and returns a one-cycle
//                response. Out-of-range addresses and the reserved size are
//                rejected with resp_err.
//                Optional: DMEM_MISALIGN_TRAP_EN - misaligned half/word
//                accesses raise resp_err instead of being forced aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [WIDTH-1:0] C_MASK_BYTE = {{(WIDTH-8){1'b0}}, 8'hFF};
    localparam logic [WIDTH-1:0] C_MASK_HALF = {{(WIDTH-16){1'b0}}, 16'hFFFF};

    state_e           r_state;
    logic [3:0]       r_cnt;
    logic             r_we;
    size_e            r_size;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_ld_ok;
    logic [1:0]       r_off;

    // In IDLE the request is taken straight from the ports so a zero-wait
    // access can hit the RAM on its accept edge; otherwise use the latch.
    logic             w_in_idle;
    logic             w_cur_we;
    size_e            w_cur_size;
    logic [WIDTH-1:0] w_cur_addr;
    logic [WIDTH-1:0] w_cur_wdata;
    logic             w_accept;
    logic             w_enter_resp;
    logic             w_oor;
    logic             w_misalign;
    logic             w_err;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_lanes;
    logic             w_ram_we;
    logic [WIDTH-1:0] w_ram_rdata;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_mask;

    assign w_in_idle    = (r_state == IDLE);
    assign w_cur_we     = w_in_idle ? req_we           : r_we;
    assign w_cur_size   = w_in_idle ? size_e'(req_size) : r_size;
    assign w_cur_addr   = w_in_idle ? req_addr         : r_addr;
    assign w_cur_wdata  = w_in_idle ? req_wdata        : r_wdata;
    assign w_accept     = w_in_idle && req_valid;
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd0));

    assign w_oor = |(w_cur_addr >> (AW + 2));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_cur_size == SZ_HALF) && w_cur_addr[0]) ||
                        ((w_cur_size == SZ_WORD) && (w_cur_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_err = w_oor || w_misalign || (w_cur_size == SZ_RSVD);

    // Lane offset forced to the access alignment, and lane-replicated write data.
    always_comb begin
        w_off   = 2'b00;
        w_lanes = w_cur_wdata;
        case (w_cur_size)
            SZ_BYTE: begin
                w_off   = w_cur_addr[1:0];
                w_lanes = {(WIDTH/8){w_cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_off   = {w_cur_addr[1], 1'b0};
                w_lanes = {(WIDTH/16){w_cur_wdata[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                w_lanes = w_cur_wdata;
            end
        endcase
    end

    assign w_be     = byte_enable(w_cur_size, w_off);
    assign w_ram_we = w_enter_resp && w_cur_we && !w_err && !rst;

    dmem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .be    (w_be),
        .addr  (w_cur_addr[AW+1:2]),
        .wdata (w_lanes),
        .rdata (w_ram_rdata)
    );

    // Responder FSM: accept, count down wait states, present one response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_ld_ok      <= 1'b0;
            r_off        <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_size      <= size_e'(req_size);
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= C_WAIT_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_ld_ok      <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_state      <= RESP;
                r_req_ready  <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_ld_ok      <= !w_cur_we && !w_err;
                r_off        <= w_off;
            end
        end
    end

    // Load data: align the registered RAM word and zero-fill above the size.
    always_comb begin
        w_shift = w_ram_rdata >> {r_off, 3'b000};
        case (r_size)
            SZ_BYTE: w_mask = C_MASK_BYTE;
            SZ_HALF: w_mask = C_MASK_HALF;
            default: w_mask = '1;
        endcase
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = (r_resp_valid && r_ld_ok) ? (w_shift & w_mask) : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Expected responses
//                are queued when a request is issued and compared when the
//                responder strobes resp_valid. Honours DMEM_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    exp_t exp_q[$];
    int   total;
    int   bad;

    dmem_responder #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h err=%b, required no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    bad++;
                    $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                             e.name, resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int waited;
        int lat;
        exp_t e;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: got req_ready=%b, required 1", name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble the inputs: only the accepted values may matter.
        req_valid = 1'b0;
        req_we    = ~we;
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && WAIT_CYCLES > 0) begin
                total++;
                if (req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_busy_ready: got req_ready=%b, required 0", name, req_ready);
                end
            end
        end while (resp_valid !== 1'b1 && lat < 40);
        total++;
        if (lat != WAIT_CYCLES + 1) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, WAIT_CYCLES + 1);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
    endtask

    task automatic test_word();
        do_req("st_word",  1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        do_req("ld_word",  1'b0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte();
        do_req("clr_10",   1'b1, 2'b10, 32'h10, 32'h0,        32'h0,        1'b0);
        do_req("st_byte",  1'b1, 2'b00, 32'h11, 32'h000000AA, 32'h0,        1'b0);
        do_req("ld_w10",   1'b0, 2'b10, 32'h10, 32'h0,        32'h0000AA00, 1'b0);
        do_req("ld_b11",   1'b0, 2'b00, 32'h11, 32'h0,        32'h000000AA, 1'b0);
        do_req("ld_h10",   1'b0, 2'b01, 32'h10, 32'h0,        32'h0000AA00, 1'b0);
    endtask

    task automatic test_half();
        do_req("clr_20",   1'b1, 2'b10, 32'h20, 32'h0,        32'h0,        1'b0);
        do_req("st_half",  1'b1, 2'b01, 32'h22, 32'hFFFF1234, 32'h0,        1'b0);
        do_req("ld_h22",   1'b0, 2'b01, 32'h22, 32'h0,        32'h00001234, 1'b0);
        do_req("ld_w20",   1'b0, 2'b10, 32'h20, 32'h0,        32'h12340000, 1'b0);
        do_req("ld_b23",   1'b0, 2'b00, 32'h23, 32'h0,        32'h00000012, 1'b0);
    endtask

    task automatic test_errors();
        do_req("st_w0",    1'b1, 2'b10, 32'h0,   32'h11223344, 32'h0,        1'b0);
        do_req("ld_oor",   1'b0, 2'b10, 32'h100, 32'h0,        32'h0,        1'b1);
        do_req("st_oor",   1'b1, 2'b10, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1);
        do_req("st_rsvd",  1'b1, 2'b11, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1);
        do_req("ld_rsvd",  1'b0, 2'b11, 32'h0,   32'h0,        32'h0,        1'b1);
        do_req("ld_w0",    1'b0, 2'b10, 32'h0,   32'h0,        32'h11223344, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int waited;
        do_req("st_w4",    1'b1, 2'b10, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0);
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h4;
        req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ready: got ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
        repeat (3) @(negedge clk);
        do_req("ld_w4",    1'b0, 2'b10, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("mis_w13",  1'b0, 2'b10, 32'h13, 32'h0, 32'h0, 1'b1);
        do_req("mis_h23",  1'b0, 2'b01, 32'h23, 32'h0, 32'h0, 1'b1);
        do_req("mis_st",   1'b1, 2'b10, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("mis_chk",  1'b0, 2'b10, 32'h20, 32'h0, 32'h12340000, 1'b0);
`else
        do_req("mis_w13",  1'b0, 2'b10, 32'h13, 32'h0, 32'h0000AA00, 1'b0);
        do_req("mis_h23",  1'b0, 2'b01, 32'h23, 32'h0, 32'h00001234, 1'b0);
        do_req("mis_st",   1'b1, 2'b01, 32'h21, 32'h0000BEEF, 32'h0, 1'b0);
        do_req("mis_chk",  1'b0, 2'b10, 32'h20, 32'h0, 32'h1234BEEF, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [8];
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            do_req("b2b_st", 1'b1, 2'b10, 32'h40 + 32'(4*i), model[i], 32'h0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            do_req("b2b_ld", 1'b0, 2'b10, 32'h40 + 32'(4*i), 32'h0, model[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            do_req("b2b_ldb", 1'b0, 2'b00, 32'h40 + 32'(i), 32'h0,
                   {24'h0, model[0][8*i +: 8]}, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid_op();
        test_misalign();
        test_back_to_back();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_resp: got %0d responses outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
